// File: rtl/ddram_responder.sv
// DDR-style memory responder: byte-enabled write bursts, fixed-latency gapless read bursts.
// Latency: first read beat READ_LATENCY cycles after acceptance; busy holds off requests during reads or when stalled.
module ddram_responder #(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ddr_rd,
  input  logic        ddr_wr,
  input  logic [28:0] ddr_addr,
  input  logic [7:0]  ddr_burstcnt,
  input  logic [63:0] ddr_din,
  input  logic [7:0]  ddr_be,
  input  logic        stall,
  output logic        ddr_busy,
  output logic [63:0] ddr_dout,
  output logic        ddr_dout_ready
);

  typedef enum logic [1:0] {IDLE, WBURST, RWAIT, RBURST} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic [7:0]              beat_cnt;
  logic [3:0]              wait_cnt;
  logic [63:0]             mem [2**ADDR_WIDTH];

  logic [7:0]              req_len;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^ddr_addr[28:ADDR_WIDTH];
  assign req_len   = (ddr_burstcnt == 8'd0) ? 8'd1 : ddr_burstcnt;
  assign mem_we    = rst_n && ddr_wr && ((state == IDLE && !stall) || state == WBURST);
  assign mem_waddr = (state == IDLE) ? ddr_addr[ADDR_WIDTH-1:0] : addr_q;

  // Write bursts never assert busy; reads hold it from acceptance until after the last beat.
  assign ddr_busy  = (state == IDLE) ? (stall && rst_n) : (state != WBURST);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 8; i++) begin
        if (ddr_be[i]) mem[mem_waddr][8*i +: 8] <= ddr_din[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      addr_q         <= '0;
      len_q          <= '0;
      beat_cnt       <= '0;
      wait_cnt       <= '0;
      ddr_dout       <= '0;
      ddr_dout_ready <= 1'b0;
    end else begin
      ddr_dout_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (!stall) begin
            if (ddr_wr) begin
              // addr_q tracks the next beat's address; beat 0 is written directly from ddr_addr.
              addr_q   <= ddr_addr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
              len_q    <= req_len;
              beat_cnt <= 8'd1;
              if (req_len > 8'd1) state <= WBURST;
            end else if (ddr_rd) begin
              addr_q   <= ddr_addr[ADDR_WIDTH-1:0];
              len_q    <= req_len;
              beat_cnt <= 8'd0;
              wait_cnt <= 4'(READ_LATENCY - 2);
              state    <= RWAIT;
            end
          end
        end
        WBURST: begin
          if (ddr_wr) begin
            addr_q   <= addr_q + ADDR_WIDTH'(1);
            beat_cnt <= beat_cnt + 8'd1;
            if (beat_cnt + 8'd1 == len_q) state <= IDLE;
          end
        end
        RWAIT: begin
          if (wait_cnt == 4'd0) begin
            ddr_dout       <= mem[addr_q];
            ddr_dout_ready <= 1'b1;
            addr_q         <= addr_q + ADDR_WIDTH'(1);
            beat_cnt       <= beat_cnt + 8'd1;
            state          <= RBURST;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RBURST: begin
          if (beat_cnt == len_q) begin
            state <= IDLE;
          end else begin
            ddr_dout       <= mem[addr_q];
            ddr_dout_ready <= 1'b1;
            addr_q         <= addr_q + ADDR_WIDTH'(1);
            beat_cnt       <= beat_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddram_responder.sv
// Bench for ddram_responder: timeline/array reference model checked every cycle, directed and random traffic.
module tb_ddram_responder;
  localparam int AW    = 10;
  localparam int RL    = 4;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ddr_rd = 1'b0;
  logic        ddr_wr = 1'b0;
  logic [28:0] ddr_addr = '0;
  logic [7:0]  ddr_burstcnt = '0;
  logic [63:0] ddr_din = '0;
  logic [7:0]  ddr_be = '0;
  logic        stall = 1'b0;
  logic        ddr_busy;
  logic [63:0] ddr_dout;
  logic        ddr_dout_ready;

  ddram_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst_n(rst_n), .ddr_rd(ddr_rd), .ddr_wr(ddr_wr), .ddr_addr(ddr_addr),
    .ddr_burstcnt(ddr_burstcnt), .ddr_din(ddr_din), .ddr_be(ddr_be), .stall(stall),
    .ddr_busy(ddr_busy), .ddr_dout(ddr_dout), .ddr_dout_ready(ddr_dout_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: memory array, read-busy end cycle, remaining write beats, expected beat queue.
  logic [63:0]   mmem [DEPTH];
  int            cyc = 0;
  int            rd_end = -1;
  int            wr_left = 0;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] ra;
  int            n_beats;
  int            exp_c[$];
  logic [63:0]   exp_d[$];

  task automatic mwrite(input logic [AW-1:0] a, input logic [63:0] d, input logic [7:0] be);
    for (int i = 0; i < 8; i++) if (be[i]) mmem[a][8*i +: 8] = d[8*i +: 8];
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_end  = -1;
      wr_left = 0;
      exp_c.delete();
      exp_d.delete();
    end else begin
      cyc++;
      if (wr_left > 0) begin
        if (ddr_wr) begin
          mwrite(wr_addr, ddr_din, ddr_be);
          wr_addr = wr_addr + 1'b1;
          wr_left--;
        end
      end else if (cyc > rd_end && !stall) begin
        n_beats = (ddr_burstcnt == 0) ? 1 : int'(ddr_burstcnt);
        if (ddr_wr) begin
          mwrite(ddr_addr[AW-1:0], ddr_din, ddr_be);
          wr_left = n_beats - 1;
          wr_addr = ddr_addr[AW-1:0] + 1'b1;
        end else if (ddr_rd) begin
          rd_end = cyc + RL - 1 + n_beats;
          ra = ddr_addr[AW-1:0];
          for (int i = 0; i < n_beats; i++) begin
            exp_c.push_back(cyc + RL - 1 + i);
            exp_d.push_back(mmem[ra]);
            ra = ra + 1'b1;
          end
        end
      end
    end
  end

  logic [63:0] last_dout = '0;
  logic        exp_busy;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_busy", 64'(ddr_busy), 64'd0);
      check("rst_ready", 64'(ddr_dout_ready), 64'd0);
      check("rst_dout", ddr_dout, 64'd0);
      last_dout = '0;
    end else begin
      exp_busy = (cyc < rd_end) ? 1'b1 : ((wr_left > 0) ? 1'b0 : stall);
      check("busy", 64'(ddr_busy), 64'(exp_busy));
      if (exp_c.size() > 0 && exp_c[0] == cyc) begin
        check("ready", 64'(ddr_dout_ready), 64'd1);
        check("dout", ddr_dout, exp_d[0]);
        last_dout = exp_d[0];
        void'(exp_c.pop_front());
        void'(exp_d.pop_front());
      end else begin
        check("ready_idle", 64'(ddr_dout_ready), 64'd0);
        check("dout_hold", ddr_dout, last_dout);
      end
    end
  end

  int          seen_c[$];
  logic [63:0] seen_d[$];
  always @(negedge clk) begin
    if (rst_n && ddr_dout_ready) begin
      seen_c.push_back(cyc);
      seen_d.push_back(ddr_dout);
    end
  end

  // Drivers run at posedge+1; req holds a request until an edge where busy was low.
  task automatic req(input logic rd, input logic wr, input logic [28:0] a, input logic [7:0] bc,
                     input logic [63:0] d, input logic [7:0] be);
    bit done;
    ddr_rd = rd; ddr_wr = wr; ddr_addr = a; ddr_burstcnt = bc; ddr_din = d; ddr_be = be;
    done = 1'b0;
    for (int k = 0; k < 2000 && !done; k++) begin
      @(negedge clk);
      if (!ddr_busy) done = 1'b1;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL req_timeout: got busy stuck expected acceptance");
    end
    @(posedge clk); #1;
    ddr_rd = 1'b0; ddr_wr = 1'b0;
    ddr_addr = 29'($urandom); ddr_burstcnt = 8'($urandom); ddr_din = {$urandom, $urandom};
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 2000 && !done; k++) begin
      @(negedge clk);
      if (!ddr_busy) done = 1'b1;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: got busy stuck expected release");
    end
    @(posedge clk); #1;
  endtask

  task automatic wr_burst(input logic [28:0] a, input logic [7:0] bc, input bit seq,
                          input int gap_at, input int gap_len, input bit rnd);
    int n;
    logic [63:0] d;
    logic [7:0] be;
    n = (bc == 0) ? 1 : int'(bc);
    for (int i = 0; i < n; i++) begin
      d  = seq ? 64'(i + 1) : {$urandom, $urandom};
      be = rnd ? 8'($urandom) : 8'hFF;
      req(rnd ? 1'($urandom) : 1'b0, 1'b1, (i == 0) ? a : 29'($urandom),
          (i == 0) ? bc : 8'($urandom), d, be);
      if (i == gap_at) gap(gap_len);
      else if (rnd && $urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
    end
  endtask

  task automatic rd_burst(input logic [28:0] a, input logic [7:0] bc, output int n0, output int acc);
    n0 = seen_d.size();
    req(1'b1, 1'b0, a, bc, 64'd0, 8'd0);
    acc = cyc;
    wait_idle();
  endtask

  int n0, acc, pulses;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    gap(3);
    rst_n = 1'b1;

    // Single write then read, first request right after reset release.
    req(1'b0, 1'b1, 29'h10, 8'd1, 64'h1122334455667788, 8'hFF);
    rd_burst(29'h10, 8'd1, n0, acc);
    check("r34_count", 64'(seen_d.size() - n0), 64'd1);
    check("r34_data", seen_d[n0], 64'h1122334455667788);
    check("r34_latency", 64'(seen_c[n0] - acc), 64'd3);

    // Fill the whole store with max-length bursts.
    for (int b = 0; b < 4; b++) wr_burst(29'(b * 255), 8'd255, 1'b0, -1, 0, 1'b0);
    wr_burst(29'd1020, 8'd4, 1'b0, -1, 0, 1'b0);

    // Wrapping write burst with a gap, then read back across the wrap.
    wr_burst(29'h3FE, 8'd4, 1'b1, 0, 2, 1'b0);
    rd_burst(29'h3FE, 8'd4, n0, acc);
    check("r35_count", 64'(seen_d.size() - n0), 64'd4);
    for (int i = 0; i < 4; i++) check("r35_data", seen_d[n0 + i], 64'(i + 1));
    check("r35_gapless", 64'(seen_c[n0 + 3] - seen_c[n0]), 64'd3);
    rd_burst(29'h1000_0000, 8'd2, n0, acc);
    check("r35_wrap0", seen_d[n0], 64'd3);
    check("r35_wrap1", seen_d[n0 + 1], 64'd4);

    // Byte enables.
    req(1'b0, 1'b1, 29'h5, 8'd1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    req(1'b0, 1'b1, 29'h5, 8'd1, 64'h0, 8'h0F);
    rd_burst(29'h5, 8'd1, n0, acc);
    check("r36_be", seen_d[n0], 64'hFFFF_FFFF_0000_0000);

    // Stall holds off a read; releasing with rd and wr together takes the write only.
    n0 = seen_d.size();
    stall = 1'b1; ddr_rd = 1'b1; ddr_addr = 29'h20; ddr_burstcnt = 8'd1;
    repeat (5) begin
      @(negedge clk);
      check("r37_stall_busy", 64'(ddr_busy), 64'd1);
    end
    @(posedge clk); #1;
    stall = 1'b0; ddr_wr = 1'b1; ddr_din = 64'hCAFE_F00D_1234_5678; ddr_be = 8'hFF;
    @(posedge clk); #1;
    ddr_rd = 1'b0; ddr_wr = 1'b0;
    gap(8);
    check("r37_no_read", 64'(seen_d.size() - n0), 64'd0);
    rd_burst(29'h20, 8'd1, n0, acc);
    check("r37_written", seen_d[n0], 64'hCAFE_F00D_1234_5678);

    // Reset in the middle of a read burst.
    wr_burst(29'h40, 8'd8, 1'b1, -1, 0, 1'b0);
    n0 = seen_d.size();
    req(1'b1, 1'b0, 29'h40, 8'd8, 64'd0, 8'd0);
    pulses = 0;
    for (int k = 0; k < 50 && pulses < 2; k++) begin
      @(negedge clk);
      if (ddr_dout_ready) pulses++;
    end
    #2 rst_n = 1'b0;
    #1;
    check("r38_async_busy", 64'(ddr_busy), 64'd0);
    check("r38_async_ready", 64'(ddr_dout_ready), 64'd0);
    check("r38_async_dout", ddr_dout, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    gap(12);
    check("r38_no_more", 64'(seen_d.size() - n0), 64'd2);
    rd_burst(29'h40, 8'd8, n0, acc);
    check("r38_count", 64'(seen_d.size() - n0), 64'd8);
    for (int i = 0; i < 8; i++) check("r38_data", seen_d[n0 + i], 64'(i + 1));

    // Burst-length limits.
    rd_burst(29'h77, 8'd0, n0, acc);
    check("r39_len0", 64'(seen_d.size() - n0), 64'd1);
    rd_burst(29'h300, 8'd255, n0, acc);
    check("r39_len255", 64'(seen_d.size() - n0), 64'd255);
    check("r39_gapless", 64'(seen_c[n0 + 254] - seen_c[n0]), 64'd254);

    // Random traffic.
    for (int op = 0; op < 80; op++) begin
      case ($urandom_range(0, 3))
        0, 1: wr_burst(29'($urandom), 8'($urandom_range(0, 6)), 1'b0, -1, 0, 1'b1);
        2: rd_burst(29'($urandom), 8'($urandom_range(0, 10)), n0, acc);
        default: begin
          req(1'b1, 1'b1, 29'($urandom), 8'd1, {$urandom, $urandom}, 8'($urandom));
          stall = 1'b1;
          gap($urandom_range(1, 4));
          stall = 1'b0;
        end
      endcase
      wait_idle();
    end
    gap(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
